// File: rtl/phold_scheduler_pkg.sv
// Shared types and widths for the PHOLD event scheduler.
package phold_scheduler_pkg;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned TIME_W = 16;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_HOLD = 2'd1,
    C_ACK  = 2'd2
  } col_state_t;

endpackage

// File: rtl/phold_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  int unsigned j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end
    end
  end

endmodule

// File: rtl/phold_scheduler.sv
// Dispatches queued events to idle PHOLD cores and merges their generated events back to the queue.
module phold_scheduler
  import phold_scheduler_pkg::*;
#(
  parameter int unsigned NCORE = 4,
  parameter int unsigned NIDB  = 3,
  parameter int unsigned NCB   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ev_valid,
  input  logic [NIDB-1:0]         ev_id,
  input  logic [TIME_W-1:0]       ev_time,
  output logic                    ev_pop,
  input  logic [NCORE-1:0]        core_ready,
  output logic [NCORE-1:0]        core_event_valid,
  output logic [NIDB-1:0]         core_event_id,
  output logic [TIME_W-1:0]       core_event_time,
  input  logic [NCORE-1:0]        core_new_ready,
  input  logic [TIME_W*NCORE-1:0] core_new_time,
  input  logic [NIDB*NCORE-1:0]   core_new_target,
  output logic [NCORE-1:0]        core_ack,
  output logic                    out_valid,
  output logic [TIME_W-1:0]       out_time,
  output logic [NIDB-1:0]         out_target,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        dispatched_cnt,
  output logic [CNT_W-1:0]        collected_cnt
);

  // ---------------- dispatch side ----------------
  logic [NCORE-1:0] pend_mask;
  logic [NCORE-1:0] avail;
  logic [NCORE-1:0] d_gnt;
  logic [NCB-1:0]   d_idx;
  logic [NCB-1:0]   disp_ptr;
  logic             d_any;
  logic             disp_go;

  // A just-launched core still reports ready for one cycle; mask it out.
  assign avail   = core_ready & ~pend_mask;
  assign disp_go = ev_valid & d_any;
  assign ev_pop  = disp_go & ~rst;

  rr_arbiter #(.N(NCORE), .W(NCB)) u_disp_arb (
    .req (avail),
    .ptr (disp_ptr),
    .gnt (d_gnt),
    .idx (d_idx),
    .any (d_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_event_valid <= '0;
      core_event_id    <= '0;
      core_event_time  <= '0;
      pend_mask        <= '0;
      disp_ptr         <= '0;
      dispatched_cnt   <= '0;
    end else if (disp_go) begin
      core_event_valid <= d_gnt;
      core_event_id    <= ev_id;
      core_event_time  <= ev_time;
      pend_mask        <= d_gnt;
      disp_ptr         <= (d_idx == NCB'(NCORE - 1)) ? '0 : d_idx + NCB'(1);
      dispatched_cnt   <= dispatched_cnt + CNT_W'(1);
    end else begin
      core_event_valid <= '0;
      pend_mask        <= '0;
    end
  end

  // ---------------- collect side ----------------
  logic [TIME_W-1:0] new_time   [NCORE];
  logic [NIDB-1:0]   new_target [NCORE];

  for (genvar k = 0; k < NCORE; k++) begin : g_unpack
    assign new_time[k]   = core_new_time[k*TIME_W +: TIME_W];
    assign new_target[k] = core_new_target[k*NIDB +: NIDB];
  end

  logic [NCORE-1:0]  c_gnt;
  logic [NCB-1:0]    c_idx;
  logic              c_any;
  logic [NCB-1:0]    col_ptr, col_ptr_d;
  logic [NCB-1:0]    col_idx, col_idx_d;
  col_state_t        state_q, state_d;
  logic              out_valid_d;
  logic [TIME_W-1:0] out_time_d;
  logic [NIDB-1:0]   out_target_d;
  logic [NCORE-1:0]  core_ack_d;
  logic [CNT_W-1:0]  col_cnt_d;

  rr_arbiter #(.N(NCORE), .W(NCB)) u_col_arb (
    .req (core_new_ready),
    .ptr (col_ptr),
    .gnt (c_gnt),
    .idx (c_idx),
    .any (c_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= C_IDLE;
      out_valid     <= 1'b0;
      out_time      <= '0;
      out_target    <= '0;
      core_ack      <= '0;
      col_ptr       <= '0;
      col_idx       <= '0;
      collected_cnt <= '0;
    end else begin
      state_q       <= state_d;
      out_valid     <= out_valid_d;
      out_time      <= out_time_d;
      out_target    <= out_target_d;
      core_ack      <= core_ack_d;
      col_ptr       <= col_ptr_d;
      col_idx       <= col_idx_d;
      collected_cnt <= col_cnt_d;
    end
  end

  // Collect FSM: capture one generated event, hold it until accepted, then ack its core.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid;
    out_time_d   = out_time;
    out_target_d = out_target;
    core_ack_d   = '0;
    col_ptr_d    = col_ptr;
    col_idx_d    = col_idx;
    col_cnt_d    = collected_cnt;
    unique case (state_q)
      C_IDLE: begin
        if (c_any) begin
          out_valid_d  = 1'b1;
          out_time_d   = new_time[c_idx];
          out_target_d = new_target[c_idx];
          col_idx_d    = c_idx;
          state_d      = C_HOLD;
        end
      end
      C_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          core_ack_d  = NCORE'(1) << col_idx;
          col_ptr_d   = (col_idx == NCB'(NCORE - 1)) ? '0 : col_idx + NCB'(1);
          col_cnt_d   = collected_cnt + CNT_W'(1);
          state_d     = C_ACK;
        end
      end
      C_ACK: begin
        state_d = C_IDLE;
      end
      default: begin
        state_d = C_IDLE;
      end
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^c_gnt;

endmodule

// File: tb/tb_phold_scheduler.sv
// Directed self-checking bench for phold_scheduler (NCORE=4, NIDB=3).
module tb_phold_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        ev_valid;
  logic [2:0]  ev_id;
  logic [15:0] ev_time;
  logic        ev_pop;
  logic [3:0]  core_ready;
  logic [3:0]  core_event_valid;
  logic [2:0]  core_event_id;
  logic [15:0] core_event_time;
  logic [3:0]  core_new_ready;
  logic [63:0] core_new_time;
  logic [11:0] core_new_target;
  logic [3:0]  core_ack;
  logic        out_valid;
  logic [15:0] out_time;
  logic [2:0]  out_target;
  logic        out_ready;
  logic [31:0] dispatched_cnt;
  logic [31:0] collected_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  phold_scheduler #(.NCORE(4), .NIDB(3), .NCB(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .ev_valid         (ev_valid),
    .ev_id            (ev_id),
    .ev_time          (ev_time),
    .ev_pop           (ev_pop),
    .core_ready       (core_ready),
    .core_event_valid (core_event_valid),
    .core_event_id    (core_event_id),
    .core_event_time  (core_event_time),
    .core_new_ready   (core_new_ready),
    .core_new_time    (core_new_time),
    .core_new_target  (core_new_target),
    .core_ack         (core_ack),
    .out_valid        (out_valid),
    .out_time         (out_time),
    .out_target       (out_target),
    .out_ready        (out_ready),
    .dispatched_cnt   (dispatched_cnt),
    .collected_cnt    (collected_cnt)
  );

  task automatic test_reset();
    rst = 1'b1; ev_valid = 1'b0; ev_id = '0; ev_time = '0; core_ready = '0;
    core_new_ready = '0; core_new_time = '0; core_new_target = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ev_pop, core_event_valid, core_ack, out_valid} !== 10'b0) begin
      $display("FAIL reset_ctrl got=%b exp=0", {ev_pop, core_event_valid, core_ack, out_valid}); failures++;
    end
    checks++;
    if ({core_event_id, core_event_time, out_time, out_target} !== 38'b0) begin
      $display("FAIL reset_data got=%h exp=0", {core_event_id, core_event_time, out_time, out_target}); failures++;
    end
    checks++;
    if ({dispatched_cnt, collected_cnt} !== 64'b0) begin
      $display("FAIL reset_cnt got=%h exp=0", {dispatched_cnt, collected_cnt}); failures++;
    end
    rst = 1'b0;
  endtask

  task automatic test_dispatch();
    core_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      ev_valid = 1'b1; ev_id = 3'(i + 1); ev_time = 16'(100 + i);
      #1;
      checks++;
      if (ev_pop !== 1'b1) begin
        $display("FAIL disp_pop%0d got=%b exp=1", i, ev_pop); failures++;
      end
      @(negedge clk);
      checks++;
      if ({core_event_valid, core_event_id, core_event_time} !== {4'(1 << i), 3'(i + 1), 16'(100 + i)}) begin
        $display("FAIL disp_launch%0d got=%b/%0d/%0d exp=%b/%0d/%0d", i, core_event_valid, core_event_id,
                 core_event_time, 4'(1 << i), i + 1, 100 + i); failures++;
      end
    end
    ev_valid = 1'b0;
    #1;
    checks++;
    if (ev_pop !== 1'b0) begin
      $display("FAIL disp_idle_pop got=%b exp=0", ev_pop); failures++;
    end
    @(negedge clk);
    checks++;
    if (core_event_valid !== 4'b0 || dispatched_cnt !== 32'd4) begin
      $display("FAIL disp_end got=%b cnt=%0d exp=0000 cnt=4", core_event_valid, dispatched_cnt); failures++;
    end
  endtask

  task automatic test_pending();
    core_ready = 4'b0001; ev_valid = 1'b1; ev_id = 3'd5; ev_time = 16'd110;
    #1;
    checks++;
    if (ev_pop !== 1'b1) begin
      $display("FAIL pend_pop1 got=%b exp=1", ev_pop); failures++;
    end
    @(negedge clk);
    checks++;
    if (core_event_valid !== 4'b0001) begin
      $display("FAIL pend_launch1 got=%b exp=0001", core_event_valid); failures++;
    end
    ev_id = 3'd6; ev_time = 16'd111;
    #1;
    checks++;
    if (ev_pop !== 1'b0) begin
      $display("FAIL pend_stale_ready got=%b exp=0", ev_pop); failures++;
    end
    @(negedge clk);
    checks++;
    if (core_event_valid !== 4'b0) begin
      $display("FAIL pend_no_double got=%b exp=0000", core_event_valid); failures++;
    end
    core_ready = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ev_pop !== 1'b0 || core_event_valid !== 4'b0) begin
        $display("FAIL pend_busy%0d got=%b/%b exp=0/0000", i, ev_pop, core_event_valid); failures++;
      end
      @(negedge clk);
    end
    core_ready = 4'b0001;
    #1;
    checks++;
    if (ev_pop !== 1'b1) begin
      $display("FAIL pend_pop2 got=%b exp=1", ev_pop); failures++;
    end
    @(negedge clk);
    checks++;
    if ({core_event_valid, core_event_id, core_event_time} !== {4'b0001, 3'd6, 16'd111}) begin
      $display("FAIL pend_launch2 got=%b/%0d/%0d exp=0001/6/111", core_event_valid, core_event_id,
               core_event_time); failures++;
    end
    ev_valid = 1'b0; core_ready = 4'b0000;
    @(negedge clk);
    checks++;
    if (dispatched_cnt !== 32'd6) begin
      $display("FAIL pend_cnt got=%0d exp=6", dispatched_cnt); failures++;
    end
  endtask

  task automatic test_collect();
    core_new_ready = 4'b1010; out_ready = 1'b1;
    core_new_time[16 +: 16] = 16'd200; core_new_target[3 +: 3] = 3'd5;
    core_new_time[48 +: 16] = 16'd300; core_new_target[9 +: 3] = 3'd6;
    @(negedge clk);
    checks++;
    if ({out_valid, out_time, out_target} !== {1'b1, 16'd200, 3'd5}) begin
      $display("FAIL col_first got=%b/%0d/%0d exp=1/200/5", out_valid, out_time, out_target); failures++;
    end
    @(negedge clk);
    checks++;
    if (core_ack !== 4'b0010 || out_valid !== 1'b0) begin
      $display("FAIL col_ack1 got=%b/%b exp=0010/0", core_ack, out_valid); failures++;
    end
    core_new_ready = 4'b1000;
    @(negedge clk);
    checks++;
    if (core_ack !== 4'b0) begin
      $display("FAIL col_ack1_end got=%b exp=0000", core_ack); failures++;
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_time, out_target} !== {1'b1, 16'd300, 3'd6}) begin
      $display("FAIL col_second got=%b/%0d/%0d exp=1/300/6", out_valid, out_time, out_target); failures++;
    end
    @(negedge clk);
    checks++;
    if (core_ack !== 4'b1000) begin
      $display("FAIL col_ack2 got=%b exp=1000", core_ack); failures++;
    end
    core_new_ready = 4'b0000;
    @(negedge clk);
    checks++;
    if (core_ack !== 4'b0 || collected_cnt !== 32'd2) begin
      $display("FAIL col_end got=%b cnt=%0d exp=0000 cnt=2", core_ack, collected_cnt); failures++;
    end
  endtask

  task automatic test_hold();
    out_ready = 1'b0; core_new_ready = 4'b0100;
    core_new_time[32 +: 16] = 16'd400; core_new_target[6 +: 3] = 3'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_time, out_target, core_ack} !== {1'b1, 16'd400, 3'd7, 4'b0}) begin
        $display("FAIL hold%0d got=%b/%0d/%0d/%b exp=1/400/7/0000", i, out_valid, out_time, out_target,
                 core_ack); failures++;
      end
    end
  endtask

  task automatic test_reset_mid();
    core_ready = 4'hF; ev_valid = 1'b1; ev_id = 3'd2; ev_time = 16'd500;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({ev_pop, core_event_valid, out_valid, core_ack} !== 10'b0) begin
      $display("FAIL rstmid_ctrl got=%b exp=0", {ev_pop, core_event_valid, out_valid, core_ack}); failures++;
    end
    checks++;
    if ({out_time, out_target, core_event_time, dispatched_cnt, collected_cnt} !== 99'b0) begin
      $display("FAIL rstmid_data got=%h exp=0", {out_time, out_target, core_event_time, dispatched_cnt,
               collected_cnt}); failures++;
    end
    @(negedge clk);
    rst = 1'b0; core_new_ready = 4'hF;
    core_new_time[0 +: 16] = 16'd600; core_new_target[0 +: 3] = 3'd1;
    #1;
    checks++;
    if (ev_pop !== 1'b1) begin
      $display("FAIL rstmid_pop got=%b exp=1", ev_pop); failures++;
    end
    @(negedge clk);
    checks++;
    if (core_event_valid !== 4'b0001) begin
      $display("FAIL rstmid_disp_ptr got=%b exp=0001", core_event_valid); failures++;
    end
    checks++;
    if ({out_valid, out_time, out_target} !== {1'b1, 16'd600, 3'd1}) begin
      $display("FAIL rstmid_col_ptr got=%b/%0d/%0d exp=1/600/1", out_valid, out_time, out_target); failures++;
    end
    ev_valid = 1'b0; core_ready = 4'h0;
  endtask

  task automatic test_back_to_back();
    core_new_ready = 4'h0; out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      core_new_time[k*16 +: 16] = 16'(1000 + k);
      core_new_target[k*3 +: 3] = 3'(k);
    end
    core_new_ready = 4'hF; out_ready = 1'b1;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_time, out_target, core_ack} !== {1'b1, 16'(1000 + e % 4), 3'(e % 4), 4'b0}) begin
        $display("FAIL b2b_offer%0d got=%b/%0d/%0d/%b exp=1/%0d/%0d/0000", e, out_valid, out_time, out_target,
                 core_ack, 1000 + e % 4, e % 4); failures++;
      end
      @(negedge clk);
      checks++;
      if (core_ack !== 4'(1 << (e % 4)) || out_valid !== 1'b0) begin
        $display("FAIL b2b_ack%0d got=%b/%b exp=%b/0", e, core_ack, out_valid, 4'(1 << (e % 4))); failures++;
      end
      @(negedge clk);
      checks++;
      if (core_ack !== 4'b0 || out_valid !== 1'b0) begin
        $display("FAIL b2b_gap%0d got=%b/%b exp=0000/0", e, core_ack, out_valid); failures++;
      end
    end
    core_new_ready = 4'h0;
    checks++;
    if (collected_cnt !== 32'd12) begin
      $display("FAIL b2b_cnt got=%0d exp=12", collected_cnt); failures++;
    end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_pending();
    test_collect();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/phold_scheduler.md
Name: phold_scheduler

Overview:
- Shares one incoming-event stream across NCORE PHOLD cores and merges their generated events back into one outgoing stream.
- Dispatch side: pops an event from the event queue and launches it on an idle core, chosen by round-robin.
- Collect side: round-robin arbitrates among cores holding a generated event, forwards it to the queue and acks that core.
- Sits between the central event queue and the array of PHOLD cores.

Parameters:
- NCORE, 4, number of cores (2..16)
- NIDB, 3, bits in LP/event id
- NCB, 2, bits in core index; must satisfy 2^NCB >= NCORE

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ev_valid  in  1  queue has an event
- ev_id  in  NIDB  event target LP
- ev_time  in  16  event timestamp
- ev_pop  out  1  event consumed this cycle
- core_ready  in  NCORE  per-core idle flag
- core_event_valid  out  NCORE  one-hot launch pulse
- core_event_id  out  NIDB  shared launch id bus
- core_event_time  out  16  shared launch time bus
- core_new_ready  in  NCORE  per-core generated-event-pending flag
- core_new_time  in  16*NCORE  packed generated times; core k at [16k+15:16k]
- core_new_target  in  NIDB*NCORE  packed generated targets
- core_ack  out  NCORE  one-hot ack pulse
- out_valid  out  1  generated event offered to queue
- out_time  out  16  generated event time
- out_target  out  NIDB  generated event target
- out_ready  in  1  queue accepts generated event
- dispatched_cnt  out  32  total events launched
- collected_cnt  out  32  total generated events forwarded

Behaviour:
- Reset (async, while rst=1): all outputs 0, both round-robin pointers 0, pending mask 0, collect FSM in C_IDLE. Reset mid-operation discards any held event.
- Dispatch eligibility: avail = core_ready & ~pend_mask.
- pend_mask holds the core launched in the previous cycle. That core still shows ready one cycle after its launch pulse, so it must not be selected twice.
- Each cycle with ev_valid=1 and avail!=0:
  - Grant the first available core at or after disp_ptr, wrapping modulo NCORE.
  - Assert ev_pop combinationally in that cycle.
  - On the next edge: register core_event_valid=one-hot(grant), core_event_id=ev_id, core_event_time=ev_time; set pend_mask=one-hot(grant); set disp_ptr=grant+1 mod NCORE; increment dispatched_cnt.
- Otherwise ev_pop=0 and, at the edge, core_event_valid=0 and pend_mask=0.
- Launch latency: event popped in cycle t; core sees event_valid in cycle t+1 (one-cycle pulse).
- Back-to-back dispatch to different cores every cycle is allowed.
- ev_valid with no available core: ev_pop=0, no state change. Event stays at queue head.
- Collect FSM:
  - C_IDLE: if core_new_ready!=0, grant first set bit at or after col_ptr, wrapping. Capture out_time/out_target from that core's slice, set out_valid=1, go C_HOLD.
  - C_HOLD: hold out_* stable. When out_ready=1: out_valid<=0, core_ack<=one-hot(grant) for exactly one cycle, col_ptr<=grant+1 mod NCORE, collected_cnt+1, go C_ACK.
  - C_ACK: core_ack<=0, go C_IDLE. The acked core's ready drops during this cycle, so it cannot be re-granted.
- Collect throughput: at most one event per 3 cycles.
- out_ready=1 in the same cycle out_valid first rises counts as a handshake.
- Counters wrap at 2^32 silently.
- Dispatch and collect paths are independent. Same-cycle launch and ack to the same core cannot occur, because a core is never both ready and pending.

Decomposition:
- Shared package: collect state encodings (C_IDLE=0, C_HOLD=1, C_ACK=2), counter width constant (32), time width constant (16).
- Natural sub-module: rr_arbiter (parameter N; inputs req[N], ptr; outputs one-hot gnt, encoded idx, any). Instantiate once for dispatch and once for collect.

Test Plan:
- Reset, then 4 events (ids 1,2,3,4; times 100..103) with all cores ready -> cores 0,1,2,3 each get a one-cycle launch pulse in consecutive cycles; ev_pop high 4 cycles; dispatched_cnt=4.
- core_ready stays high one cycle after launch of core 0, only core 0 ready, 2 events queued -> second event not popped until core 0 re-readies; never double-launched.
- core_new_ready=4'b1010, times 200/300, out_ready=1 -> core 1 forwarded first (out_time=200), ack pulse on bit 1, then core 3 (300); collected_cnt=2.
- Hold out_ready=0 for 5 cycles in C_HOLD -> out_valid, out_time, out_target stable; no core_ack.
- Assert rst during C_HOLD with dispatch active -> all outputs 0 immediately, pointers 0; after release, core 0 is granted first.
- All 4 cores continuously pending new events for 12 collects -> grants 0,1,2,3 repeating; no ack wider than 1 cycle; 3 cycles per event.
